demux_stream: RTL and testbench

Registered one-hot stream demultiplexer: one valid/ready input stream is steered to one or more of N output lanes by a select vector sent with each beat. Each lane has a single-entry output register, so downstream stalls on one lane never block the others. It is the distribution counterpart of the one-hot OR-combining mux in the common library and sits wherever a shared source fans out to per-client streams.

---
 rtl/demux_stream.sv | 67 ++++++
 tb/tb_demux_stream.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/demux_stream.sv
// demux_stream: registered one-hot stream demultiplexer.
// One valid/ready input stream is steered to any subset of N output lanes,
// selected per beat by in_sel. Each lane owns a single-entry output register,
// so a stalled consumer only back-pressures beats that target its own lane.
// Beats accepted with an all-zero select are discarded and counted.
module demux_stream #(
  parameter int DW = 1,
  parameter int N  = 1,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          in_valid,
  input  logic [N-1:0]  in_sel,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic [N-1:0]  out_valid,
  output logic [N*DW-1:0] out_data,
  input  logic [N-1:0]  out_ready,
  output logic [CW-1:0] drop_count
);

  logic [N-1:0] lane_free;
  logic [N-1:0] lane_load;
  logic         accept;
  logic         sel_none;

  // A lane can take a new beat when it is empty or its current beat leaves
  // this cycle. The input is ready only if every targeted lane can take it,
  // which makes a multi-hot beat all-or-nothing. in_valid is deliberately
  // kept out of in_ready.
  always_comb begin
    lane_free = ~out_valid | out_ready;
    in_ready  = &(~in_sel | lane_free);
    accept    = in_valid & in_ready;
    sel_none  = (in_sel == '0);
    lane_load = in_sel & {N{accept}};
  end

  // Per-lane holding registers: load wins over drain, so a lane can sustain
  // one beat per cycle; a stalled lane keeps valid and data untouched.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      out_valid <= '0;
      out_data  <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (lane_load[i]) begin
          out_valid[i]           <= 1'b1;
          out_data[i*DW +: DW]   <= in_data;
        end else if (out_ready[i]) begin
          out_valid[i]           <= 1'b0;
        end
      end
    end
  end

  // Saturating count of accepted beats that targeted no lane.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      drop_count <= '0;
    end else if (accept && sel_none && (drop_count != {CW{1'b1}})) begin
      drop_count <= drop_count + CW'(1);
    end
  end

endmodule

// File: tb/tb_demux_stream.sv
// Bench for demux_stream: directed vector table, hand-written corner
// sequences, and a randomized run against per-lane queue scoreboards.
module tb_demux_stream;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = 16;

  logic              clk = 1'b0;
  logic              nreset = 1'b0;
  logic              in_valid = 1'b0;
  logic [N-1:0]      in_sel = '0;
  logic [DW-1:0]     in_data = '0;
  logic              in_ready;
  logic [N-1:0]      out_valid;
  logic [N*DW-1:0]   out_data;
  logic [N-1:0]      out_ready = '0;
  logic [CW-1:0]     drop_count;

  logic              s_valid = 1'b0;
  logic [0:0]        s_sel = '0;
  logic [7:0]        s_data = '0;
  logic              s_in_ready;
  logic [0:0]        s_out_valid;
  logic [7:0]        s_out_data;
  logic [0:0]        s_out_ready = '0;
  logic [1:0]        s_drop;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  demux_stream #(.DW(DW), .N(N), .CW(CW)) dut (
    .clk(clk), .nreset(nreset), .in_valid(in_valid), .in_sel(in_sel),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .drop_count(drop_count)
  );

  demux_stream #(.DW(8), .N(1), .CW(2)) dut_sat (
    .clk(clk), .nreset(nreset), .in_valid(s_valid), .in_sel(s_sel),
    .in_data(s_data), .in_ready(s_in_ready), .out_valid(s_out_valid),
    .out_data(s_out_data), .out_ready(s_out_ready), .drop_count(s_drop)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        v;
    logic [3:0]  sel;
    logic [7:0]  d;
    logic [3:0]  ordy;
    logic        exp_rdy;
    logic [3:0]  exp_ov;
    logic [31:0] exp_od;
    logic [15:0] exp_drop;
  } vec_t;

  vec_t tbl [11];

  logic [7:0] mq [N][$];
  int         exp_drops;

  task automatic do_reset();
    @(negedge clk);
    nreset = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // fields: valid sel data out_ready | in_ready out_valid out_data drop_count
    tbl[0]  = '{1'b1, 4'b0010, 8'hAA, 4'b0000, 1'b1, 4'b0010, 32'h0000AA00, 16'd0};
    tbl[1]  = '{1'b1, 4'b1000, 8'h55, 4'b0000, 1'b1, 4'b1010, 32'h5500AA00, 16'd0};
    tbl[2]  = '{1'b1, 4'b0010, 8'h77, 4'b0000, 1'b0, 4'b1010, 32'h5500AA00, 16'd0};
    tbl[3]  = '{1'b1, 4'b0010, 8'h77, 4'b0010, 1'b1, 4'b1010, 32'h55007700, 16'd0};
    tbl[4]  = '{1'b1, 4'b1001, 8'h3C, 4'b0000, 1'b0, 4'b1010, 32'h55007700, 16'd0};
    tbl[5]  = '{1'b1, 4'b1001, 8'h3C, 4'b1000, 1'b1, 4'b1011, 32'h3C00773C, 16'd0};
    tbl[6]  = '{1'b0, 4'b1111, 8'hFF, 4'b1111, 1'b1, 4'b0000, 32'h3C00773C, 16'd0};
    tbl[7]  = '{1'b1, 4'b0000, 8'h99, 4'b0000, 1'b1, 4'b0000, 32'h3C00773C, 16'd1};
    tbl[8]  = '{1'b0, 4'b0100, 8'h12, 4'b0000, 1'b1, 4'b0000, 32'h3C00773C, 16'd1};
    tbl[9]  = '{1'b1, 4'b0100, 8'h12, 4'b0100, 1'b1, 4'b0100, 32'h3C12773C, 16'd1};
    tbl[10] = '{1'b0, 4'b0100, 8'h34, 4'b0000, 1'b0, 4'b0100, 32'h3C12773C, 16'd1};

    // Reset values
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_data", 64'(out_data), 64'h0);
    chk("rst_drop", 64'(drop_count), 64'h0);
    do_reset();
    chk("rst_in_ready", 64'(in_ready), 64'h1);

    // Directed table: stall isolation, drain+load, broadcast, zero select
    for (int k = 0; k < 11; k++) begin
      in_valid  = tbl[k].v;
      in_sel    = tbl[k].sel;
      in_data   = tbl[k].d;
      out_ready = tbl[k].ordy;
      @(negedge clk);
      chk($sformatf("tbl%0d_in_ready", k), 64'(in_ready), 64'(tbl[k].exp_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_out_valid", k), 64'(out_valid), 64'(tbl[k].exp_ov));
      chk($sformatf("tbl%0d_out_data", k), 64'(out_data), 64'(tbl[k].exp_od));
      chk($sformatf("tbl%0d_drop", k), 64'(drop_count), 64'(tbl[k].exp_drop));
    end
    in_valid = 1'b0;
    out_ready = '0;
    do_reset();

    // Single-lane streaming into lane 2 at full rate
    out_ready = 4'b0100;
    in_sel    = 4'b0100;
    for (int k = 1; k <= 16; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(k);
      @(negedge clk);
      chk("stream_in_ready", 64'(in_ready), 64'h1);
      @(posedge clk);
      #1;
      chk("stream_out_valid", 64'(out_valid), 64'b0100);
      chk("stream_lane2", 64'(out_data[23:16]), 64'(k));
    end

    // Zero-select drops
    out_ready = 4'b1111;
    in_sel    = 4'b0000;
    for (int k = 1; k <= 5; k++) begin
      in_data = 8'hE0 + 8'(k);
      @(negedge clk);
      chk("zero_in_ready", 64'(in_ready), 64'h1);
      @(posedge clk);
      #1;
      chk("zero_out_valid", 64'(out_valid), 64'h0);
    end
    chk("zero_drop_count", 64'(drop_count), 64'd5);

    // Mid-traffic asynchronous reset with lanes 1 and 2 full
    out_ready = 4'b0000;
    in_sel    = 4'b0110;
    in_data   = 8'h5A;
    @(posedge clk);
    #1;
    chk("pre_rst_out_valid", 64'(out_valid), 64'b0110);
    in_valid = 1'b0;
    #2;
    nreset = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'h0);
    chk("async_rst_out_data", 64'(out_data), 64'h0);
    chk("async_rst_drop", 64'(drop_count), 64'h0);
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_out_valid", 64'(out_valid), 64'h0);
    chk("post_rst_in_ready", 64'(in_ready), 64'h1);

    // Saturation of a 2-bit drop counter
    s_valid = 1'b1;
    s_sel   = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      s_data = 8'(k);
      @(posedge clk);
      #1;
      chk("sat_drop", 64'(s_drop), 64'((k > 3) ? 3 : k));
      chk("sat_out_valid", 64'(s_out_valid), 64'h0);
    end
    s_valid = 1'b0;

    // Randomized traffic against per-lane FIFO scoreboards
    do_reset();
    exp_drops = 0;
    for (int c = 0; c < 10000; c++) begin
      logic exp_rdy;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sel    = 4'($urandom);
      in_data   = 8'($urandom);
      out_ready = 4'($urandom);
      @(negedge clk);
      exp_rdy = 1'b1;
      for (int i = 0; i < N; i++) begin
        chk("rnd_out_valid", 64'(out_valid[i]), 64'(mq[i].size() != 0));
        if (mq[i].size() != 0)
          chk("rnd_out_data", 64'(out_data[i*DW +: DW]), 64'(mq[i][0]));
        if (in_sel[i] && mq[i].size() != 0 && !out_ready[i])
          exp_rdy = 1'b0;
      end
      chk("rnd_in_ready", 64'(in_ready), 64'(exp_rdy));
      for (int i = 0; i < N; i++)
        if (mq[i].size() != 0 && out_ready[i])
          void'(mq[i].pop_front());
      if (in_valid && exp_rdy) begin
        if (in_sel == '0)
          exp_drops++;
        for (int i = 0; i < N; i++)
          if (in_sel[i])
            mq[i].push_back(in_data);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("rnd_drop_count", 64'(drop_count), 64'(exp_drops));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
